// File: rtl/spi_master_byte_if.sv
// Byte-wide SPI master bus: request/response handshake toward the user
// and the serial pins toward the slave.
interface spi_master_byte_if;
    logic       start;
    logic [7:0] tx_data;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    modport master (
        input  start, tx_data, miso,
        output sclk, mosi, cs_n, busy, done, rx_data
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, mosi, cs_n, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_byte.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master: one byte per start, MSB first,
// cs setup and hold of CLK_DIV cycles around 8 sclk periods.
module spi_master_byte #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_byte_if.master bus
);
    localparam int unsigned          DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       edge_q, edge_d;
    logic [6:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // bit 7 goes straight to mosi; only bits 6..0 need shifting
                    tx_sr_d = bus.tx_data[6:0];
                    rx_sr_d = '0;
                    mosi_d  = bus.tx_data[7];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = XFER;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            XFER: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 4'd1;
                    if (!sclk_q) begin
                        rx_sr_d = {rx_sr_q[6:0], bus.miso};
                    end else if (edge_q != 4'd15) begin
                        // final falling edge keeps bit 0 on mosi through HOLD
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                    end
                    if (edge_q == 4'd15) begin
                        state_d = HOLD;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    mosi_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: loopback, constant miso, streaming,
// reset abort, a small mode-0 slave model and the CLK_DIV=1 corner.
module tb_spi_master_byte;
    localparam logic [7:0] SLV_RESP = 8'hC3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_byte_if bus0();
    spi_master_byte_if bus1();

    spi_master_byte #(.CLK_DIV(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    spi_master_byte #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    logic       sel;
    logic       tb_start;
    logic [7:0] tb_tx;
    logic [1:0] mode;
    logic [7:0] slv_tx;
    logic [7:0] slv_rx;
    logic       slv_miso;

    assign slv_miso = slv_tx[7];

    assign bus0.start   = tb_start & ~sel;
    assign bus1.start   = tb_start & sel;
    assign bus0.tx_data = tb_tx;
    assign bus1.tx_data = tb_tx;
    assign bus0.miso    = (mode == 2'd0) ? bus0.mosi :
                          (mode == 2'd1) ? 1'b1 :
                          (mode == 2'd2) ? 1'b0 : slv_miso;
    assign bus1.miso    = bus1.mosi;

    // Mode-0 slave: capture on sclk rise, advance response on sclk fall
    always @(posedge bus0.sclk) if (!bus0.cs_n) slv_rx <= {slv_rx[6:0], bus0.mosi};
    always @(negedge bus0.sclk or posedge bus0.cs_n) begin
        if (bus0.cs_n) slv_tx <= SLV_RESP;
        else           slv_tx <= {slv_tx[6:0], 1'b0};
    end

    logic       m_sclk, m_mosi, m_cs_n, m_busy, m_done;
    logic [7:0] m_rx;
    assign m_sclk = sel ? bus1.sclk    : bus0.sclk;
    assign m_mosi = sel ? bus1.mosi    : bus0.mosi;
    assign m_cs_n = sel ? bus1.cs_n    : bus0.cs_n;
    assign m_busy = sel ? bus1.busy    : bus0.busy;
    assign m_done = sel ? bus1.done    : bus0.done;
    assign m_rx   = sel ? bus1.rx_data : bus0.rx_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input int d, input string tag);
        int         nb, rises, first_r, last_r;
        logic       prev;
        logic [7:0] mb;
        tb_tx    = tx;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        chk($sformatf("%s.cs_low", tag), 32'(m_cs_n), 32'd0);
        nb = 0; rises = 0; first_r = 0; last_r = 0; prev = 1'b0; mb = '0;
        while (m_busy === 1'b1 && nb < 2000) begin
            nb++;
            if (m_sclk && !prev) begin
                if (rises == 0) first_r = nb;
                last_r = nb;
                rises++;
                mb = {mb[6:0], m_mosi};
            end
            prev = m_sclk;
            tick();
        end
        chk($sformatf("%s.busy_len", tag), 32'(nb), 32'(18 * d));
        chk($sformatf("%s.rises", tag), 32'(rises), 32'd8);
        chk($sformatf("%s.rise_span", tag), 32'(last_r - first_r), 32'(14 * d));
        chk($sformatf("%s.mosi_bits", tag), 32'(mb), 32'(tx));
        chk($sformatf("%s.done", tag), 32'(m_done), 32'd1);
        chk($sformatf("%s.rx", tag), 32'(m_rx), 32'(exp_rx));
        chk($sformatf("%s.cs_high", tag), 32'(m_cs_n), 32'd1);
        chk($sformatf("%s.mosi_idle", tag), 32'(m_mosi), 32'd0);
        tick();
        chk($sformatf("%s.done_pulse", tag), 32'(m_done), 32'd0);
    endtask

    initial begin
        int   n, rises;
        logic prev, seen_done;

        rst = 1'b1; tb_start = 1'b0; sel = 1'b0; mode = 2'd0; tb_tx = '0;
        tick(); tick();
        chk("rst.cs_n", 32'(m_cs_n), 32'd1);
        chk("rst.sclk", 32'(m_sclk), 32'd0);
        chk("rst.mosi", 32'(m_mosi), 32'd0);
        chk("rst.busy", 32'(m_busy), 32'd0);
        chk("rst.done", 32'(m_done), 32'd0);
        chk("rst.rx",   32'(m_rx),   32'd0);
        rst = 1'b0;
        tick();

        mode = 2'd0; xfer(8'hA5, 8'hA5, 2, "loop_a5");
        mode = 2'd1; xfer(8'h00, 8'hFF, 2, "miso1");
        mode = 2'd2; xfer(8'hFF, 8'h00, 2, "miso0");

        // Start held high; tx_data disturbed mid-transfer
        mode = 2'd0; tb_tx = 8'h3C; tb_start = 1'b1;
        tick();
        repeat (10) tick();
        tb_tx = 8'h99;
        repeat (5) tick();
        tb_tx = 8'h3C;
        n = 0;
        while (!m_done && n < 200) begin tick(); n++; end
        chk("stream.done1", 32'(m_done), 32'd1);
        chk("stream.rx1", 32'(m_rx), 32'h3C);
        chk("stream.cs_gap", 32'(m_cs_n), 32'd1);
        tick();
        n = 1;
        chk("stream.cs_relow", 32'(m_cs_n), 32'd0);
        while (!m_done && n < 200) begin tick(); n++; end
        tb_start = 1'b0;
        chk("stream.period", 32'(n), 32'd37);
        chk("stream.rx2", 32'(m_rx), 32'h3C);
        tick(); tick();

        // Reset after the third sclk rising edge
        tb_tx = 8'hA5; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        n = 0; rises = 0;
        while (rises < 3 && n < 200) begin
            prev = m_sclk;
            tick();
            n++;
            if (m_sclk && !prev) rises++;
        end
        chk("abort.rises", 32'(rises), 32'd3);
        rst = 1'b1;
        tick();
        chk("abort.cs_n", 32'(m_cs_n), 32'd1);
        chk("abort.sclk", 32'(m_sclk), 32'd0);
        chk("abort.mosi", 32'(m_mosi), 32'd0);
        chk("abort.busy", 32'(m_busy), 32'd0);
        chk("abort.done", 32'(m_done), 32'd0);
        chk("abort.rx",   32'(m_rx),   32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (60) begin
            tick();
            if (m_done) seen_done = 1'b1;
        end
        chk("abort.no_done", 32'(seen_done), 32'd0);
        chk("abort.rx_held", 32'(m_rx), 32'd0);
        xfer(8'h6E, 8'h6E, 2, "after_abort");

        mode = 2'd3;
        xfer(8'h5A, SLV_RESP, 2, "slave");
        chk("slave.rx_at_slave", 32'(slv_rx), 32'h5A);

        sel = 1'b1;
        xfer(8'h81, 8'h81, 1, "div1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Mode-0 SPI master that generates the serial stream for the 8-bit SPI slave (tt_um_spi) and captures its response. It sits directly upstream of that slave.
- Accepts one byte per start request and produces cs_n, sclk and mosi. It samples miso and returns the received byte with a done pulse.
- Used as on-chip stimulus/loopback source and as the reusable bus driver for later blocks.

Parameters:
CLK_DIV, 2, sclk half-period in clk cycles; legal range 1..255; counter width is $clog2(CLK_DIV+1).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request transfer; sampled only while busy=0
tx_data  input  8  byte to send, MSB first; latched on accepted start
miso  input  1  serial data from slave
sclk  output  1  SPI clock, idle low (CPOL=0)
mosi  output  1  serial data to slave
cs_n  output  1  chip select, active-low
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when rx_data is valid
rx_data  output  8  last received byte, held until next done

Behaviour:
- Reset (rst=1 at clk edge) sets sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0x00 and state IDLE, and clears counters. Reset has priority over everything.
- Reset mid-transfer aborts immediately: no done, rx_data keeps 0x00. The slave sees cs_n rise on the same edge.
- States: IDLE, SETUP, XFER, HOLD. All outputs are registered.
- IDLE, start=1 at an edge:
  - latch tx_data into tx shift register; clear rx shift register;
  - cs_n<=0, busy<=1, mosi<=tx_data[7], div counter<=0, go to SETUP.
  - start=0 keeps all outputs unchanged; done is cleared to 0.
- SETUP: CLK_DIV cycles of cs-to-sclk setup. On the last cycle go to XFER with div counter=0; sclk remains 0.
- XFER: div counter counts 0..CLK_DIV-1. At terminal count sclk toggles and the edge counter increments (0..15).
  - Rising edge (sclk 0->1): shift miso into rx shift register LSB, using the miso value present in that clk cycle.
  - Falling edge (sclk 1->0): mosi<=next tx bit (bit 6 down to bit 0).
  - After the 16th toggle (8th falling edge, sclk=0) go to HOLD; mosi is held at the bit-0 value.
- HOLD: CLK_DIV cycles. On the last cycle: cs_n<=1, busy<=0, done<=1, rx_data<=rx shift register, mosi<=0; go to IDLE.
- Timing:
  - busy is high for exactly 18*CLK_DIV clk cycles.
  - done is high on the first cycle busy is low.
  - sclk period is 2*CLK_DIV cycles; exactly 8 rising edges per transfer.
- start while busy=1 is ignored: no queueing, no effect on the current transfer.
- start=1 in the cycle done=1 (state IDLE) is accepted. The back-to-back transfer begins with cs_n low on the next edge, so cs_n is high for exactly 1 cycle between transfers.
- tx_data changes during busy do not affect the transmitted byte.
- done never asserts without a preceding accepted start. It is never high for more than 1 cycle.

Test Plan:
- Loopback: miso tied to mosi, CLK_DIV=2, tx_data=0xA5, start pulse -> mosi serialises 1,0,1,0,0,1,0,1. busy is high for 36 cycles, then done=1 for 1 cycle with rx_data=0xA5, then cs_n=1.
- miso tied 1, tx_data=0x00 -> mosi 0 throughout, 8 sclk rising edges, rx_data=0xFF. Then miso tied 0, tx_data=0xFF -> rx_data=0x00.
- Start held high continuously, tx_data=0x3C -> done pulses every 36+1 cycles, each rx_data=0x3C (loopback). A start mid-transfer with tx_data=0x99 is ignored and the current byte completes unchanged.
- Reset asserted after the 3rd sclk rising edge -> next cycle shows cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00. No done follows. A new start afterwards completes normally.
- CLK_DIV=1, tx_data=0x81, loopback -> sclk period is 2 cycles, busy is high 18 cycles, rx_data=0x81.
- Integration with tt_um_spi slave: drive byte 0x5A -> the slave receives 0x5A. The master rx_data equals the slave's preloaded response byte.
